// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register-file hazard scoreboard.
package reg_scoreboard_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int MAX_OUT  = 4;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // Reason an issue is held; the first matching cause wins.
    typedef enum logic [2:0] {
        HZ_NONE,
        HZ_RAW1,
        HZ_RAW2,
        HZ_WAW,
        HZ_FULL
    } hz_cause_e;

endpackage

// File: rtl/sb_hazard_check.sv
// Combinational hazard detection against the pending bitmap and the same-cycle writeback.
module sb_hazard_check
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
    parameter int ADDR_W   = reg_scoreboard_pkg::ADDR_W,
    parameter int MAX_OUT  = reg_scoreboard_pkg::MAX_OUT,
    parameter int CNT_W    = $clog2(MAX_OUT + 1)
) (
    input  logic [NUM_REGS-1:0] pending,
    input  logic [CNT_W-1:0]    out_count,
    input  logic                issue_use_rs1,
    input  logic [ADDR_W-1:0]   issue_rs1,
    input  logic                issue_use_rs2,
    input  logic [ADDR_W-1:0]   issue_rs2,
    input  logic                issue_wr_rd,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    output logic                wb_hit,
    output logic                wb_clears,
    output hz_cause_e           cause
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic raw1;
    logic raw2;
    logic waw;
    logic full;

    assign wb_hit    = wb_valid && (wb_addr != REG_ZERO);
    assign wb_clears = wb_hit && pending[wb_addr];

    // A writeback landing this cycle is bypassed by the register file, so it resolves the hazard.
    assign raw1 = issue_use_rs1 && (issue_rs1 != REG_ZERO) && pending[issue_rs1]
                  && !(wb_hit && (wb_addr == issue_rs1));
    assign raw2 = issue_use_rs2 && (issue_rs2 != REG_ZERO) && pending[issue_rs2]
                  && !(wb_hit && (wb_addr == issue_rs2));
    assign waw  = issue_wr_rd && (issue_rd != REG_ZERO) && pending[issue_rd]
                  && !(wb_hit && (wb_addr == issue_rd));
    assign full = (out_count == CNT_MAX) && !wb_clears;

    always_comb begin
        cause = HZ_NONE;
        if (raw1)      cause = HZ_RAW1;
        else if (raw2) cause = HZ_RAW2;
        else if (waw)  cause = HZ_WAW;
        else if (full) cause = HZ_FULL;
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-stage scoreboard: tracks in-flight register writes, stalls on RAW/WAW/capacity.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
    parameter int ADDR_W   = reg_scoreboard_pkg::ADDR_W,
    parameter int MAX_OUT  = reg_scoreboard_pkg::MAX_OUT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           issue_valid,
    input  logic [ADDR_W-1:0]              issue_rs1,
    input  logic [ADDR_W-1:0]              issue_rs2,
    input  logic                           issue_use_rs1,
    input  logic                           issue_use_rs2,
    input  logic [ADDR_W-1:0]              issue_rd,
    input  logic                           issue_wr_rd,
    output logic                           issue_stall,
    output logic                           issue_fire,
    input  logic                           wb_valid,
    input  logic [ADDR_W-1:0]              wb_addr,
    input  logic                           flush,
    output logic [NUM_REGS-1:0]            pending,
    output logic [$clog2(MAX_OUT+1)-1:0]   out_count,
    output logic                           wb_err
);

    localparam int               CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;

    logic      wb_hit;
    logic      wb_clears;
    logic      set_new;
    hz_cause_e cause;

    sb_hazard_check #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .MAX_OUT  (MAX_OUT),
        .CNT_W    (CNT_W)
    ) u_hazard (
        .pending       (pending_q),
        .out_count     (count_q),
        .issue_use_rs1 (issue_use_rs1),
        .issue_rs1     (issue_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_rs2     (issue_rs2),
        .issue_wr_rd   (issue_wr_rd),
        .issue_rd      (issue_rd),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_hit        (wb_hit),
        .wb_clears     (wb_clears),
        .cause         (cause)
    );

    assign issue_stall = issue_valid && (cause != HZ_NONE);
    assign issue_fire  = issue_valid && !issue_stall && !flush;
    assign set_new     = issue_fire && issue_wr_rd && (issue_rd != REG_ZERO);

    // Clear before set so a same-cycle writeback and reissue of one rd leaves it pending.
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        err_d     = err_q;
        if (flush) begin
            pending_d = '0;
            count_d   = '0;
        end else begin
            if (wb_hit && !pending_q[wb_addr]) err_d = 1'b1;
            if (wb_clears) begin
                pending_d[wb_addr] = 1'b0;
                count_d            = count_d - CNT_ONE;
            end
            if (set_new) begin
                pending_d[issue_rd] = 1'b1;
                count_d             = count_d + CNT_ONE;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign pending   = pending_q;
    assign out_count = count_q;
    assign wb_err    = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against a queue-based reference model.
module tb_reg_scoreboard;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rs1 = '0;
    logic [AW-1:0] issue_rs2 = '0;
    logic          issue_use_rs1 = 1'b0;
    logic          issue_use_rs2 = 1'b0;
    logic [AW-1:0] issue_rd = '0;
    logic          issue_wr_rd = 1'b0;
    logic          issue_stall;
    logic          issue_fire;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic          flush = 1'b0;
    logic [NR-1:0] pending;
    logic [2:0]    out_count;
    logic          wb_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the set of registers with a write in flight, plus the sticky error flag.
    int pend[$];
    bit m_err = 1'b0;

    reg_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .MAX_OUT(MO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_rd      (issue_rd),
        .issue_wr_rd   (issue_wr_rd),
        .issue_stall   (issue_stall),
        .issue_fire    (issue_fire),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .flush         (flush),
        .pending       (pending),
        .out_count     (out_count),
        .wb_err        (wb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_has(int r);
        if (r == 0) return 1'b0;
        foreach (pend[i]) if (pend[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NR-1:0] m_bits();
        logic [NR-1:0] b = '0;
        foreach (pend[i]) b[pend[i]] = 1'b1;
        return b;
    endfunction

    function automatic bit m_wbhit();
        return wb_valid && (int'(wb_addr) != 0);
    endfunction

    function automatic bit m_blocked(bit use_it, int r);
        return use_it && m_has(r) && !(m_wbhit() && int'(wb_addr) == r);
    endfunction

    function automatic bit m_stall();
        bit full;
        full = (pend.size() == MO) && !(m_wbhit() && m_has(int'(wb_addr)));
        return issue_valid && (m_blocked(issue_use_rs1, int'(issue_rs1)) ||
                               m_blocked(issue_use_rs2, int'(issue_rs2)) ||
                               m_blocked(issue_wr_rd, int'(issue_rd)) || full);
    endfunction

    function automatic bit m_fire();
        return issue_valid && !m_stall() && !flush;
    endfunction

    task automatic model_step();
        bit fire;
        fire = m_fire();
        if (flush) begin
            pend.delete();
        end else begin
            if (m_wbhit()) begin
                if (!m_has(int'(wb_addr))) m_err = 1'b1;
                foreach (pend[i]) if (pend[i] == int'(wb_addr)) begin
                    pend.delete(i);
                    break;
                end
            end
            if (fire && issue_wr_rd && int'(issue_rd) != 0) pend.push_back(int'(issue_rd));
        end
    endtask

    always @(negedge clk) begin
        chk("pending", pending, m_bits());
        chk("out_count", out_count, pend.size());
        chk("wb_err", wb_err, m_err);
        chk("issue_stall", issue_stall, m_stall());
        chk("issue_fire", issue_fire, m_fire());
    end

    task automatic set_in(bit v, int a1, bit u1, int a2, bit u2, int d, bit w,
                          bit wv, int wa, bit f);
        issue_valid   = v;
        issue_rs1     = AW'(a1);
        issue_use_rs1 = u1;
        issue_rs2     = AW'(a2);
        issue_use_rs2 = u2;
        issue_rd      = AW'(d);
        issue_wr_rd   = w;
        wb_valid      = wv;
        wb_addr       = AW'(wa);
        flush         = f;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic issue_wr(int d);
        set_in(1, 0, 0, 0, 0, d, 1, 0, 0, 0);
        tick();
    endtask

    task automatic wb(int a);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, a, 0);
        tick();
    endtask

    task automatic async_reset();
        idle();
        #1 rst_n = 1'b0;
        pend.delete();
        m_err = 1'b0;
        #1;
        chk("async_rst_pending", pending, 32'h0);
        chk("async_rst_count", out_count, 3'd0);
        chk("async_rst_err", wb_err, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        #12;
        chk("reset_pending", pending, 32'h0);
        chk("reset_count", out_count, 3'd0);
        chk("reset_err", wb_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic tracking and same-cycle bypass release
        issue_wr(5);
        chk("track_pending", pending, 32'h0000_0020);
        chk("track_count", out_count, 3'd1);
        set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("raw1_stall", issue_stall, 1'b1);
        set_in(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
        #1 chk("raw1_bypass_stall", issue_stall, 1'b0);
        chk("raw1_bypass_fire", issue_fire, 1'b1);
        tick();
        chk("track_cleared", pending, 32'h0);

        // RAW on rs2 only
        issue_wr(9);
        set_in(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        #1 chk("raw2_stall", issue_stall, 1'b1);
        wb(9);

        // WAW released by same-cycle writeback; set wins over clear
        issue_wr(7);
        set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        #1 chk("waw_stall", issue_stall, 1'b1);
        set_in(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
        #1 chk("waw_wb_fire", issue_fire, 1'b1);
        tick();
        chk("setclr_pending", pending, 32'h0000_0080);
        chk("setclr_count", out_count, 3'd1);
        wb(7);

        // Capacity
        for (int r = 1; r <= 4; r++) issue_wr(r);
        chk("cap_count_full", out_count, 3'd4);
        set_in(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        #1 chk("cap_full_stall", issue_stall, 1'b1);
        set_in(1, 0, 0, 0, 0, 6, 1, 1, 2, 0);
        #1 chk("cap_wb_fire", issue_fire, 1'b1);
        tick();
        chk("cap_count", out_count, 3'd4);
        chk("cap_pending", pending, 32'h0000_005A);
        wb(1); wb(3); wb(4); wb(6);
        chk("cap_drained", out_count, 3'd0);

        // x0 never tracked, never an error
        set_in(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        #1 chk("x0_stall", issue_stall, 1'b0);
        tick();
        chk("x0_pending", pending, 32'h0);
        wb(0);
        chk("x0_err", wb_err, 1'b0);

        // Flush discards everything, including the same-cycle issue
        issue_wr(8); issue_wr(10); issue_wr(11);
        set_in(1, 0, 0, 0, 0, 9, 1, 0, 0, 1);
        #1 chk("flush_fire", issue_fire, 1'b0);
        tick();
        chk("flush_pending", pending, 32'h0);
        chk("flush_count", out_count, 3'd0);

        // Sticky error, then asynchronous reset
        wb(12);
        chk("err_set", wb_err, 1'b1);
        issue_wr(3);
        chk("err_sticky", wb_err, 1'b1);
        async_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int wa;
            if (pend.size() > 0 && $urandom_range(0, 1) == 1)
                wa = pend[$urandom_range(0, pend.size() - 1)];
            else
                wa = $urandom_range(0, 7);
            set_in($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), wa,
                   $urandom_range(0, 99) < 3);
            tick();
            if (i == 1500) async_reset();
        end

        idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
